stage_sequencer: RTL

Drives the 3-bit `Stage` code, `NOP_FLAG`, and instruction-boundary status consumed by the stage-enable decoder in the control unit. It walks each instruction through five stages: Fetch, Decode, Execute, Memory, Write Back. It supports free-run, single-step, and halt-at-boundary operation, and stalls the Memory stage until data memory reports ready. It sits between the top-level run controls and the enable decoder.

---
 rtl/stage_pkg.sv | 22 ++
 rtl/stage_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/stage_pkg.sv
// ---------------------------------------------------------------------------
// stage_pkg
// Shared constants for the instruction stage sequencer and the stage-enable
// decoder that consumes its Stage code.
//   STAGE_W             : width of the Stage code
//   STAGE_*             : stage encodings (0 = idle, 1..5 = active stages)
//   NOP_OPCODE_DEFAULT  : opcode that marks a no-operation instruction
// ---------------------------------------------------------------------------
package stage_pkg;

  localparam int STAGE_W = 3;

  localparam logic [STAGE_W-1:0] STAGE_IDLE    = 3'd0;
  localparam logic [STAGE_W-1:0] STAGE_FETCH   = 3'd1;
  localparam logic [STAGE_W-1:0] STAGE_DECODE  = 3'd2;
  localparam logic [STAGE_W-1:0] STAGE_EXECUTE = 3'd3;
  localparam logic [STAGE_W-1:0] STAGE_MEMORY  = 3'd4;
  localparam logic [STAGE_W-1:0] STAGE_WB      = 3'd5;

  localparam logic [3:0] NOP_OPCODE_DEFAULT = 4'h0;

endpackage : stage_pkg

// File: rtl/stage_sequencer.sv
// ---------------------------------------------------------------------------
// stage_sequencer
// Walks each instruction through Fetch, Decode, Execute, Memory, Write Back
// and reports the current stage to the stage-enable decoder. Supports
// free-run (Run), single-step (Step) and halt-at-boundary (Halt_Req), and
// stalls the Memory stage until data memory is ready.
//
// Ports
//   Clock        : clock, all state updates on the rising edge
//   Reset        : synchronous, active-high
//   Run          : level, issue instructions back-to-back while high
//   Step         : from idle, one high cycle runs exactly one instruction
//   Halt_Req     : pulse, finish the current instruction then go idle
//   Mem_Ready    : data memory ready, looked at only in the Memory stage
//   IR_Opcode    : opcode field of the instruction register (valid stage 2+)
//   Stage        : registered stage code, 0 = idle, 1..5 = active
//   NOP_FLAG     : current instruction is a NOP
//   Instr_Done   : one-cycle pulse after the Write Back stage completes
//   Busy         : Stage is not idle
//   Instr_Count  : retired instructions, wraps modulo 2^COUNT_W
// ---------------------------------------------------------------------------
module stage_sequencer
  import stage_pkg::*;
#(
  parameter int                    OPCODE_W   = 4,
  parameter logic [OPCODE_W-1:0]   NOP_OPCODE = OPCODE_W'(NOP_OPCODE_DEFAULT),
  parameter int                    COUNT_W    = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Run,
  input  logic                Step,
  input  logic                Halt_Req,
  input  logic                Mem_Ready,
  input  logic [OPCODE_W-1:0] IR_Opcode,
  output logic [STAGE_W-1:0]  Stage,
  output logic                NOP_FLAG,
  output logic                Instr_Done,
  output logic                Busy,
  output logic [COUNT_W-1:0]  Instr_Count
);

  logic [STAGE_W-1:0] state_q, state_d;
  logic               step_mode_q, step_mode_d;     // instruction was started by Step alone
  logic               halt_pending_q, halt_pending_d;
  logic               nop_q, nop_d;
  logic               done_q, done_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic opcode_is_nop;
  logic halt_now;

  assign opcode_is_nop = (IR_Opcode == NOP_OPCODE);
  // A halt arriving during Write Back itself must still stop this boundary.
  assign halt_now      = halt_pending_q | Halt_Req;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    state_d        = state_q;
    step_mode_d    = step_mode_q;
    halt_pending_d = halt_pending_q;
    nop_d          = nop_q;

    case (state_q)
      STAGE_IDLE: begin
        // Run wins over Step, so a simultaneous Step still free-runs.
        if (Run) begin
          state_d     = STAGE_FETCH;
          step_mode_d = 1'b0;
        end else if (Step) begin
          state_d     = STAGE_FETCH;
          step_mode_d = 1'b1;
        end
      end
      STAGE_FETCH:   state_d = STAGE_DECODE;
      STAGE_DECODE: begin
        state_d = STAGE_EXECUTE;
        nop_d   = opcode_is_nop;
      end
      STAGE_EXECUTE: state_d = STAGE_MEMORY;
      STAGE_MEMORY: begin
        // NOPs never touch data memory, so they never stall.
        if (Mem_Ready || nop_q) state_d = STAGE_WB;
      end
      STAGE_WB: begin
        nop_d   = 1'b0;
        state_d = (Run && !halt_now && !step_mode_q) ? STAGE_FETCH : STAGE_IDLE;
      end
      default: state_d = STAGE_IDLE;
    endcase

    if (state_q != STAGE_IDLE && Halt_Req) halt_pending_d = 1'b1;
    if (state_d == STAGE_IDLE)             halt_pending_d = 1'b0;
  end

  assign done_d  = (state_q == STAGE_WB);
  assign count_d = done_d ? count_q + COUNT_W'(1) : count_q;

  always_ff @(posedge Clock) begin
    // NOTE: reset is sampled on the clock edge here (synchronous), and all
    // state uses non-blocking assignment so every register sees the values
    // from before this edge.
    if (Reset) begin
      state_q        <= STAGE_IDLE;
      step_mode_q    <= 1'b0;
      halt_pending_q <= 1'b0;
      nop_q          <= 1'b0;
      done_q         <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      step_mode_q    <= step_mode_d;
      halt_pending_q <= halt_pending_d;
      nop_q          <= nop_d;
      done_q         <= done_d;
      count_q        <= count_d;
    end
  end

  always_comb begin
    NOP_FLAG = 1'b0;
    if (state_q == STAGE_DECODE)     NOP_FLAG = opcode_is_nop;
    else if (state_q >= STAGE_EXECUTE) NOP_FLAG = nop_q;
  end

  assign Stage       = state_q;
  assign Busy        = (state_q != STAGE_IDLE);
  assign Instr_Done  = done_q;
  assign Instr_Count = count_q;

endmodule : stage_sequencer
